// File: rtl/mmul_sequencer_if.sv
`default_nettype none
// =====================================================================
// mmul_sequencer_if : command and result handshake bundle for mmul_sequencer
// Rev 1.0
// =====================================================================
interface mmul_sequencer_if #(
  parameter int N     = 4,
  parameter int K_MAX = 64
);
  localparam int C_KW = $clog2(K_MAX + 1);
  localparam int C_IW = $clog2(K_MAX);
  localparam int C_RW = $clog2(N);

  logic            start;
  logic [C_KW-1:0] cfg_k;
  logic            abort;
  logic            out_ready;
  logic            busy;
  logic            done;
  logic            err_cfg;
  logic            acc_clear;
  logic            feed_en;
  logic [C_IW-1:0] feed_idx;
  logic            array_en;
  logic            drain_en;
  logic            res_valid;
  logic [C_RW-1:0] res_row;
  logic            res_last;

  modport master (
    output start, cfg_k, abort, out_ready,
    input  busy, done, err_cfg, acc_clear, feed_en, feed_idx,
           array_en, drain_en, res_valid, res_row, res_last
  );

  modport slave (
    input  start, cfg_k, abort, out_ready,
    output busy, done, err_cfg, acc_clear, feed_en, feed_idx,
           array_en, drain_en, res_valid, res_row, res_last
  );
endinterface
`default_nettype wire

// File: rtl/mmul_sequencer.sv
`default_nettype none
// =====================================================================
// mmul_sequencer : clear/feed/flush/drain sequencer for one N x N systolic pass
// Rev 1.0
// =====================================================================
module mmul_sequencer #(
  parameter int N         = 4,
  parameter int K_MAX     = 64,
  parameter int FLUSH_CYC = 2*N-1
) (
  input  logic             clk,
  input  logic             reset_n,
  mmul_sequencer_if.slave  bus
);
  localparam int C_IW   = $clog2(K_MAX);
  localparam int C_RW   = $clog2(N);
  localparam int C_MAXC = (K_MAX > FLUSH_CYC) ? ((K_MAX > 2*N) ? K_MAX : 2*N)
                                              : ((FLUSH_CYC > 2*N) ? FLUSH_CYC : 2*N);
  localparam int C_CW   = $clog2(C_MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_FLUSH = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          r_state;
  logic [C_CW-1:0] r_cnt;
  logic [C_CW-1:0] r_k_last;
  logic            r_busy;
  logic            r_done;
  logic            r_err_cfg;
  logic            r_acc_clear;
  logic            r_feed_en;
  logic [C_IW-1:0] r_feed_idx;
  logic            r_array_en;
  logic            r_drain_pre;
  logic            r_res_valid;
  logic [C_RW-1:0] r_res_row;
  logic            r_res_last;

  logic [C_CW-1:0] w_s_next;
  logic            w_cfg_ok;
  logic            w_drain_en;

  assign w_s_next   = r_cnt + C_CW'(1);
  assign w_cfg_ok   = (bus.cfg_k != '0) && (int'(bus.cfg_k) <= K_MAX);
  // Drain steps before the deskew buffer is primed are unconditional.
  assign w_drain_en = r_drain_pre | (r_res_valid & bus.out_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_k_last    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_cfg   <= 1'b0;
      r_acc_clear <= 1'b0;
      r_feed_en   <= 1'b0;
      r_feed_idx  <= '0;
      r_array_en  <= 1'b0;
      r_drain_pre <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_row   <= '0;
      r_res_last  <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_err_cfg   <= 1'b0;
      r_acc_clear <= 1'b0;
      r_feed_en   <= 1'b0;
      r_array_en  <= 1'b0;
      if (bus.abort) begin
        r_state     <= S_IDLE;
        r_cnt       <= '0;
        r_busy      <= 1'b0;
        r_feed_idx  <= '0;
        r_drain_pre <= 1'b0;
        r_res_valid <= 1'b0;
        r_res_row   <= '0;
        r_res_last  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              if (w_cfg_ok) begin
                r_state     <= S_CLEAR;
                r_k_last    <= C_CW'(bus.cfg_k) - C_CW'(1);
                r_cnt       <= '0;
                r_busy      <= 1'b1;
                r_acc_clear <= 1'b1;
              end else begin
                r_err_cfg   <= 1'b1;
              end
            end
          end
          S_CLEAR: begin
            r_state    <= S_FEED;
            r_cnt      <= '0;
            r_feed_en  <= 1'b1;
            r_feed_idx <= '0;
            r_array_en <= 1'b1;
          end
          S_FEED: begin
            r_array_en <= 1'b1;
            if (r_cnt == r_k_last) begin
              r_state    <= S_FLUSH;
              r_cnt      <= '0;
              r_feed_idx <= '0;
            end else begin
              r_cnt      <= w_s_next;
              r_feed_en  <= 1'b1;
              r_feed_idx <= C_IW'(w_s_next);
            end
          end
          S_FLUSH: begin
            if (r_cnt == C_CW'(FLUSH_CYC-1)) begin
              r_state     <= S_DRAIN;
              r_cnt       <= '0;
              r_drain_pre <= 1'b1;
            end else begin
              r_cnt      <= w_s_next;
              r_array_en <= 1'b1;
            end
          end
          S_DRAIN: begin
            // Without a drain step everything holds, freezing the presented row.
            if (w_drain_en) begin
              if (r_res_last) begin
                r_state     <= S_DONE;
                r_done      <= 1'b1;
                r_cnt       <= '0;
                r_res_valid <= 1'b0;
                r_res_row   <= '0;
                r_res_last  <= 1'b0;
              end else begin
                r_cnt       <= w_s_next;
                r_drain_pre <= (w_s_next < C_CW'(N));
                r_res_valid <= (w_s_next >= C_CW'(N));
                r_res_row   <= (w_s_next >= C_CW'(N)) ? C_RW'(w_s_next - C_CW'(N)) : '0;
                r_res_last  <= (w_s_next == C_CW'(2*N-1));
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err_cfg   = r_err_cfg;
  assign bus.acc_clear = r_acc_clear;
  assign bus.feed_en   = r_feed_en;
  assign bus.feed_idx  = r_feed_idx;
  assign bus.array_en  = r_array_en;
  assign bus.drain_en  = w_drain_en;
  assign bus.res_valid = r_res_valid;
  assign bus.res_row   = r_res_row;
  assign bus.res_last  = r_res_last;
endmodule
`default_nettype wire

// File: tb/tb_mmul_sequencer.sv
`default_nettype none
// =====================================================================
// tb_mmul_sequencer : scenario and randomized checks against a pass-timeline model
// Rev 1.0
// =====================================================================
module tb_mmul_sequencer;
  localparam int N     = 4;
  localparam int K_MAX = 64;
  localparam int F     = 2*N-1;
  localparam int KW    = $clog2(K_MAX + 1);
  localparam int IW    = $clog2(K_MAX);
  localparam int RW    = $clog2(N);

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          err_cfg;
    logic          acc_clear;
    logic          feed_en;
    logic [IW-1:0] feed_idx;
    logic          array_en;
    logic          drain_en;
    logic          res_valid;
    logic [RW-1:0] res_row;
    logic          res_last;
  } outs_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   cyc;

  mmul_sequencer_if #(.N(N), .K_MAX(K_MAX)) bus ();

  mmul_sequencer #(.N(N), .K_MAX(K_MAX), .FLUSH_CYC(F)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pass model: cycles since the accepted start, K, and rows handed over so far.
  int m_on, m_t, m_k, m_sent, m_err;

  task automatic model_reset();
    m_on = 0; m_t = 0; m_k = 0; m_sent = 0; m_err = 0;
  endtask

  function automatic outs_t model_expect();
    outs_t e;
    int    d;
    e = '0;
    e.err_cfg = (m_err != 0);
    if (m_on != 0) begin
      d = 2 + m_k + F;
      e.busy      = 1'b1;
      e.acc_clear = (m_t == 1);
      e.feed_en   = (m_t >= 2) && (m_t <= m_k + 1);
      if (e.feed_en) e.feed_idx = IW'(m_t - 2);
      e.array_en  = (m_t >= 2) && (m_t < d);
      if (m_t >= d && m_t < d + N) begin
        e.drain_en = 1'b1;
      end else if (m_t >= d + N) begin
        if (m_sent < N) begin
          e.res_valid = 1'b1;
          e.res_row   = RW'(m_sent);
          e.res_last  = (m_sent == N-1);
          e.drain_en  = bus.out_ready;
        end else begin
          e.done = 1'b1;
        end
      end
    end
    return e;
  endfunction

  task automatic model_advance();
    int d;
    m_err = 0;
    if (!reset_n) begin
      m_on = 0;
    end else if (m_on != 0) begin
      d = 2 + m_k + F;
      if (bus.abort) m_on = 0;
      else if (m_t >= d + N && m_sent == N) m_on = 0;
      else begin
        if (m_t >= d + N && bus.out_ready) m_sent++;
        m_t++;
      end
    end else if (!bus.abort && bus.start) begin
      if (int'(bus.cfg_k) >= 1 && int'(bus.cfg_k) <= K_MAX) begin
        m_on = 1; m_t = 1; m_k = int'(bus.cfg_k); m_sent = 0;
      end else begin
        m_err = 1;
      end
    end
  endtask

  function automatic outs_t observe();
    outs_t o;
    o.busy      = bus.busy;
    o.done      = bus.done;
    o.err_cfg   = bus.err_cfg;
    o.acc_clear = bus.acc_clear;
    o.feed_en   = bus.feed_en;
    o.feed_idx  = bus.feed_en ? bus.feed_idx : '0;
    o.array_en  = bus.array_en;
    o.drain_en  = bus.drain_en;
    o.res_valid = bus.res_valid;
    o.res_row   = bus.res_valid ? bus.res_row : '0;
    o.res_last  = bus.res_last;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_advance();
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b1; bus.cfg_k = '0;
  endtask

  task automatic test_reset();
    outs_t o;
    @(negedge clk);
    #1 o = observe();
    checks++;
    if (o !== '0) begin errors++; $display("FAIL reset_hold got=%h want=0", o); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 o = observe();
    checks++;
    if (o !== '0) begin errors++; $display("FAIL reset_release got=%h want=0", o); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    outs_t e, o;
    int first_valid = -1, done_at = -1;
    cyc = 0;
    for (int i = 0; i < 26; i++) begin
      bus.start = (cyc == 0); bus.cfg_k = KW'(4);
      #1 e = model_expect(); o = observe();
      checks++;
      if (o !== e) begin errors++; $display("FAIL basic cyc=%0d got=%h want=%h", cyc, o, e); end
      if (o.res_valid && first_valid < 0) first_valid = cyc;
      if (o.done) done_at = cyc;
      tick();
    end
    checks++;
    if (first_valid != 17) begin errors++; $display("FAIL basic_first_valid got=%0d want=17", first_valid); end
    checks++;
    if (done_at != 21) begin errors++; $display("FAIL basic_done got=%0d want=21", done_at); end
    idle_inputs();
  endtask

  task automatic test_stall();
    outs_t e, o;
    int done_at = -1;
    cyc = 0;
    for (int i = 0; i < 28; i++) begin
      bus.start = (cyc == 0); bus.cfg_k = KW'(4);
      bus.out_ready = !(cyc >= 18 && cyc <= 20);
      #1 e = model_expect(); o = observe();
      checks++;
      if (o !== e) begin errors++; $display("FAIL stall cyc=%0d got=%h want=%h", cyc, o, e); end
      if (cyc == 19 && !(o.res_valid && o.res_row == RW'(1) && !o.drain_en)) begin
        errors++; $display("FAIL stall_hold valid=%b row=%0d drain=%b want 1/1/0", o.res_valid, o.res_row, o.drain_en);
      end
      if (o.done) done_at = cyc;
      tick();
    end
    checks++;
    if (done_at != 24) begin errors++; $display("FAIL stall_done got=%0d want=24", done_at); end
    idle_inputs();
  endtask

  task automatic test_cfg_err();
    outs_t e, o;
    int bad [2];
    int err_at, side;
    bad[0] = 0; bad[1] = K_MAX + 1;
    for (int b = 0; b < 2; b++) begin
      cyc = 0; err_at = -1; side = 0;
      for (int i = 0; i < 4; i++) begin
        bus.start = (cyc == 0); bus.cfg_k = KW'(bad[b]);
        #1 e = model_expect(); o = observe();
        checks++;
        if (o !== e) begin errors++; $display("FAIL cfg_err k=%0d cyc=%0d got=%h want=%h", bad[b], cyc, o, e); end
        if (o.err_cfg) err_at = cyc;
        if (o.busy || o.acc_clear) side = 1;
        tick();
      end
      checks++;
      if (err_at != 1 || side != 0) begin
        errors++; $display("FAIL cfg_err_pulse k=%0d err_at=%0d busy_or_clear=%0d want 1/0", bad[b], err_at, side);
      end
    end
    idle_inputs();
  endtask

  task automatic test_abort();
    outs_t e, o;
    int first_done = -1;
    cyc = 0;
    for (int i = 0; i < 32; i++) begin
      bus.cfg_k = KW'(4);
      bus.start = (cyc == 0) || (cyc == 5) || (cyc == 6);
      bus.abort = (cyc == 4) || (cyc == 5);
      #1 e = model_expect(); o = observe();
      checks++;
      if (o !== e) begin errors++; $display("FAIL abort cyc=%0d got=%h want=%h", cyc, o, e); end
      if (o.done && first_done < 0) first_done = cyc;
      tick();
    end
    checks++;
    if (first_done != 27) begin errors++; $display("FAIL abort_done got=%0d want=27", first_done); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    outs_t e, o;
    int done_at = -1;
    cyc = 0;
    for (int i = 0; i < 42; i++) begin
      bus.start = (cyc == 0) || (cyc == 20);
      bus.cfg_k = (cyc < 20) ? KW'(4) : KW'(2);
      if (cyc == 15) begin
        reset_n = 1'b0;
        model_reset();
      end
      if (cyc == 17) reset_n = 1'b1;
      #1 e = model_expect(); o = observe();
      if (cyc == 15) begin
        checks++;
        if (o !== '0) begin errors++; $display("FAIL async_reset got=%h want=0", o); end
      end
      checks++;
      if (o !== e) begin errors++; $display("FAIL reset_mid cyc=%0d got=%h want=%h", cyc, o, e); end
      if (o.done) done_at = cyc;
      tick();
    end
    checks++;
    if (done_at != 39) begin errors++; $display("FAIL reset_mid_done got=%0d want=39", done_at); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    outs_t e, o;
    int feeds [3];
    int clr_n = 0, dones = 0, fall_at = -1, clr2_at = -1, last_idx = -1, prev_busy = 0;
    feeds[0] = 0; feeds[1] = 0; feeds[2] = 0;
    cyc = 0;
    bus.start = 1'b1; bus.cfg_k = KW'(1);
    for (int i = 0; i < 200 && dones < 2; i++) begin
      #1 e = model_expect(); o = observe();
      checks++;
      if (o !== e) begin errors++; $display("FAIL b2b cyc=%0d got=%h want=%h", cyc, o, e); end
      if (prev_busy != 0 && !o.busy && fall_at < 0) fall_at = cyc;
      prev_busy = o.busy;
      if (o.acc_clear) begin
        clr_n++;
        if (clr_n == 1) bus.cfg_k = KW'(K_MAX);
        if (clr_n == 2) begin clr2_at = cyc; bus.start = 1'b0; end
      end
      if (o.feed_en && clr_n >= 1 && clr_n <= 2) begin
        feeds[clr_n]++;
        last_idx = int'(o.feed_idx);
      end
      if (o.done) dones++;
      tick();
    end
    checks++;
    if (dones != 2) begin errors++; $display("FAIL b2b_timeout dones=%0d want=2", dones); end
    checks++;
    if (feeds[1] != 1 || feeds[2] != K_MAX) begin
      errors++; $display("FAIL b2b_feed_len got=%0d/%0d want=1/%0d", feeds[1], feeds[2], K_MAX);
    end
    checks++;
    if (last_idx != K_MAX-1) begin errors++; $display("FAIL b2b_last_idx got=%0d want=%0d", last_idx, K_MAX-1); end
    checks++;
    if (clr2_at - fall_at != 1) begin
      errors++; $display("FAIL b2b_restart busy_fall=%0d clear=%0d want gap 1", fall_at, clr2_at);
    end
    idle_inputs();
    repeat (2) tick();
  endtask

  task automatic test_random();
    outs_t e, o;
    int r;
    for (int i = 0; i < 2500; i++) begin
      bus.start     = ($urandom_range(0, 3) == 0);
      bus.abort     = ($urandom_range(0, 63) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 15));
      if (r == 0)      bus.cfg_k = '0;
      else if (r == 1) bus.cfg_k = KW'(K_MAX + 1 + int'($urandom_range(0, 2)));
      else if (r == 2) bus.cfg_k = KW'(K_MAX);
      else             bus.cfg_k = KW'($urandom_range(1, 8));
      #1 e = model_expect(); o = observe();
      checks++;
      if (o !== e) begin errors++; $display("FAIL random i=%0d got=%h want=%h", i, o, e); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_basic();
    test_stall();
    test_cfg_err();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
